// File: rtl/mul8_dot_acc.sv
// Streaming 8x8 unsigned dot-product stage: registered multiply, then accumulate LEN
// products and offer the wrapped sum with a sticky carry flag over valid/ready.
module mul8_dot_acc #(
  parameter int LEN   = 4,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [15:0]      p_q;
  logic             p_vld_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [ACC_W:0]   sum_d;
  logic             accept_d;

  // The extra top bit of the sum is the carry that feeds the sticky overflow flag.
  assign sum_d    = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, p_q};
  assign accept_d = (state_q == ACC) && in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      p_vld_q     <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      p_vld_q     <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      p_vld_q <= accept_d;
      if (accept_d) begin
        p_q <= a * b;
      end
      if (p_vld_q) begin
        acc_q <= sum_d[ACC_W-1:0];
        ovf_q <= ovf_q | sum_d[ACC_W];
      end
      case (state_q)
        IDLE: begin
          state_q    <= ACC;
          in_ready_q <= 1'b1;
        end
        ACC: begin
          if (accept_d) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(LEN - 1)) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        // Only the final product can still be in flight here; it lands this edge.
        DRAIN: begin
          if (p_vld_q) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q == DRAIN) || (state_q == DONE) ||
                     ((state_q == ACC) && (p_vld_q || (cnt_q != '0)));

endmodule
